nv_nvdla_cacc_dbuf_rd_sched: RTL and testbench
==============================================

// Module: nv_nvdla_cacc_dbuf_rd_sched
// PURPOSE
//  Read scheduler for the CACC delivery buffer ring. Tracks entries committed by the
//  assembly-side writer and issues one read per entry, in ring order, whenever the
//  delivery buffer reports dbuf_rd_ready. Tags the final read of a layer with
//  layer_end, then waits for the last slice to drain to SDP before pulsing layer_done.
//  Sits between the CACC register/assembly control and the delivery buffer read port.
// PARAMETERS
//  DBUF_AW    4   read address width; ring depth = 2**DBUF_AW
//  LAYER_CW   16  width of the per-layer entry count
// PORTS
//  nvdla_core_clk     in   1           core clock
//  nvdla_core_rstn    in   1           synchronous active-low reset
//  reg_op_en          in   1           single-cycle layer start pulse
//  reg_layer_entries  in   LAYER_CW    dbuf entries in layer; sampled on accepted reg_op_en
//  wr_done            in   1           writer committed one entry this cycle
//  dbuf_rd_ready      in   1           delivery buffer can accept a read
//  dbuf_rd_en         out  1           read strobe to delivery buffer
//  dbuf_rd_addr       out  DBUF_AW     read address (ring pointer)
//  dbuf_rd_layer_end  out  1           qualifies the last read of the layer
//  dbuf_full          out  1           occupancy == 2**DBUF_AW; writer must stall
//  dbuf_occ           out  DBUF_AW+1   committed-but-unread entries
//  layer_busy         out  1           state != IDLE
//  layer_done         out  1           single-cycle pulse after last slice drains
//  sched_err          out  1           sticky protocol error (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rstn low at posedge): state=IDLE, rd_ptr=0, occ=0, rd_cnt=0, all outputs 0.
//  FSM: IDLE -(reg_op_en & entries!=0)-> RUN -(last read issued)-> DRAIN
//       -(dbuf_rd_ready)-> DONE -> IDLE (1 cycle each for DONE).
//   - reg_op_en with entries==0 in IDLE: go straight to DONE, no reads issued.
//   - reg_op_en outside IDLE: ignored.
//  Read issue (combinational): dbuf_rd_en = RUN & (occ!=0) & dbuf_rd_ready.
//   - dbuf_rd_addr = rd_ptr; dbuf_rd_layer_end = dbuf_rd_en & (rd_cnt == entries-1).
//   - On dbuf_rd_en: rd_ptr <= rd_ptr+1 (wraps 2**DBUF_AW-1 -> 0); rd_cnt++.
//   - Max one read per cycle; the delivery buffer drops ready for its slice count.
//  Occupancy: occ <= occ + wr_done - dbuf_rd_en; simultaneous wr_done and rd_en leave occ
//   unchanged. wr_done accepted in any state (writer may prefill before reg_op_en).
//   dbuf_full, dbuf_occ driven from the occ register.
//  rd_ptr and occ persist across layers (ring is continuous); rd_cnt clears on entry to RUN.
//  DRAIN: no reads; leave when dbuf_rd_ready=1 (last slice consumed by SDP).
//  DONE: layer_done=1 for exactly one cycle; layer_busy=1 in RUN/DRAIN/DONE.
//  Reset mid-layer: returns to reset values immediately; no layer_done.
//  Error conditions: wr_done while occ==2**DBUF_AW (overflow, occ saturates);
//   entries remaining while occ never refills is NOT an error (scheduler simply waits).
// CONFIGURATION
//  NVDLA_CACC_DBUF_SCHED_ERR_EN defined: sched_err sets on overflow, or on reg_op_en
//   received while layer_busy; clears only on reset.
//  Not defined: no error logic built; sched_err tied 0; overflow still saturates occ.
// TESTING
//  1. Reset, 3 wr_done, op_en entries=3, ready high 1 of 3 cycles -> reads addr 0,1,2;
//     layer_end only on addr 2; layer_done 1 cycle after ready returns; occ=0.
//  2. rd_ptr=14, op_en entries=4 with entries prefilled -> addr 14,15,0,1; wrap clean.
//  3. 16 wr_done -> dbuf_full=1, occ=16; extra wr_done -> occ stays 16, sched_err=1
//     with ERR_EN, 0 without.
//  4. wr_done and dbuf_rd_en same cycle at occ=5 -> occ stays 5.
//  5. op_en entries=0 -> layer_done pulse, zero dbuf_rd_en, rd_ptr unchanged.
//  6. Reset asserted in DRAIN -> all outputs 0 next cycle, no layer_done; new layer runs.

Source files
------------

// File: rtl/nv_nvdla_cacc_dbuf_rd_sched.sv
// CACC delivery-buffer read scheduler: ring-order reads, layer end tagging, drain wait.
// Optional sticky protocol error logic is built when NVDLA_CACC_DBUF_SCHED_ERR_EN is defined.
module nv_nvdla_cacc_dbuf_rd_sched #(
    parameter int DBUF_AW  = 4,
    parameter int LAYER_CW = 16
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rstn,
    input  logic                reg_op_en,
    input  logic [LAYER_CW-1:0] reg_layer_entries,
    input  logic                wr_done,
    input  logic                dbuf_rd_ready,
    output logic                dbuf_rd_en,
    output logic [DBUF_AW-1:0]  dbuf_rd_addr,
    output logic                dbuf_rd_layer_end,
    output logic                dbuf_full,
    output logic [DBUF_AW:0]    dbuf_occ,
    output logic                layer_busy,
    output logic                layer_done,
    output logic                sched_err
);

    localparam logic [DBUF_AW:0] OCC_MAX = (DBUF_AW+1)'(1 << DBUF_AW);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state;
    logic [DBUF_AW-1:0]  rd_ptr;
    logic [DBUF_AW:0]    occ;
    logic [LAYER_CW-1:0] rd_cnt;
    logic [LAYER_CW-1:0] entries;
    logic                occ_full;
    logic                last_rd;
    logic                wr_inc;

    always_comb begin
        occ_full          = (occ == OCC_MAX);
        last_rd           = (rd_cnt == (entries - LAYER_CW'(1)));
        dbuf_rd_en        = (state == RUN) && (occ != '0) && dbuf_rd_ready;
        dbuf_rd_layer_end = dbuf_rd_en && last_rd;
        dbuf_rd_addr      = rd_ptr;
        dbuf_full         = occ_full;
        dbuf_occ          = occ;
        layer_busy        = (state != IDLE);
        layer_done        = (state == DONE);
        // A write into a full ring is only absorbed if a read frees a slot in the same cycle.
        wr_inc            = wr_done && (!occ_full || dbuf_rd_en);
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            state   <= IDLE;
            rd_cnt  <= '0;
            entries <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (reg_op_en) begin
                        entries <= reg_layer_entries;
                        rd_cnt  <= '0;
                        state   <= (reg_layer_entries == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (dbuf_rd_en) begin
                        rd_cnt <= rd_cnt + LAYER_CW'(1);
                        if (last_rd) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dbuf_rd_ready) state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Ring pointer and occupancy run continuously across layers.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (dbuf_rd_en) rd_ptr <= rd_ptr + DBUF_AW'(1);
            case ({wr_inc, dbuf_rd_en})
                2'b10:   occ <= occ + (DBUF_AW+1)'(1);
                2'b01:   occ <= occ - (DBUF_AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

`ifdef NVDLA_CACC_DBUF_SCHED_ERR_EN
    logic err;
    logic overflow;

    always_comb overflow = wr_done && occ_full && !dbuf_rd_en;

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            err <= 1'b0;
        end else if (overflow || (reg_op_en && (state != IDLE))) begin
            err <= 1'b1;
        end
    end

    assign sched_err = err;
`else
    assign sched_err = 1'b0;
`endif

endmodule

// File: tb/tb_nv_nvdla_cacc_dbuf_rd_sched.sv
// Self-checking bench for nv_nvdla_cacc_dbuf_rd_sched with a transaction-level ring model.
module tb_nv_nvdla_cacc_dbuf_rd_sched;

    logic        clk = 1'b0;
    logic        rstn;
    logic        reg_op_en;
    logic [15:0] reg_layer_entries;
    logic        wr_done;
    logic        dbuf_rd_ready;
    logic        dbuf_rd_en;
    logic [3:0]  dbuf_rd_addr;
    logic        dbuf_rd_layer_end;
    logic        dbuf_full;
    logic [4:0]  dbuf_occ;
    logic        layer_busy;
    logic        layer_done;
    logic        sched_err;

`ifdef NVDLA_CACC_DBUF_SCHED_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int exp_ptr = 0;
    int exp_occ = 0;
    bit exp_err = 1'b0;

    nv_nvdla_cacc_dbuf_rd_sched #(.DBUF_AW(4), .LAYER_CW(16)) dut (
        .nvdla_core_clk    (clk),
        .nvdla_core_rstn   (rstn),
        .reg_op_en         (reg_op_en),
        .reg_layer_entries (reg_layer_entries),
        .wr_done           (wr_done),
        .dbuf_rd_ready     (dbuf_rd_ready),
        .dbuf_rd_en        (dbuf_rd_en),
        .dbuf_rd_addr      (dbuf_rd_addr),
        .dbuf_rd_layer_end (dbuf_rd_layer_end),
        .dbuf_full         (dbuf_full),
        .dbuf_occ          (dbuf_occ),
        .layer_busy        (layer_busy),
        .layer_done        (layer_done),
        .sched_err         (sched_err)
    );

    always #5 clk = ~clk;

    // One clock cycle: inputs change just after the rising edge, outputs sampled at the falling edge.
    task automatic drive(input logic rn, input logic op, input logic [15:0] ent,
                         input logic wr, input logic rdy);
        @(posedge clk);
        #1;
        rstn = rn; reg_op_en = op; reg_layer_entries = ent; wr_done = wr; dbuf_rd_ready = rdy;
        @(negedge clk);
    endtask

    task automatic prefill(input int k);
        for (int i = 0; i < k; i++) drive(1'b1, 1'b0, 16'd0, 1'b1, 1'b0);
        exp_occ = exp_occ + k;
    endtask

    task automatic check_status(input string tag);
        n_chk++;
        if (dbuf_occ !== 5'(exp_occ) || dbuf_full !== (exp_occ == 16) || sched_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s: occ=%0d full=%0b err=%0b, required occ=%0d full=%0b err=%0b",
                     tag, dbuf_occ, dbuf_full, sched_err, exp_occ, exp_occ == 16, exp_err);
        end
    endtask

    // mode 0: random ready, 1: ready one cycle in three, 2: ready always high
    task automatic run_layer(input int n, input int wr_more, input int mode, input bit extra_op);
        int reads, writes, t_last, t_done_exp, dones, start_occ;
        bit rdy, wr, op2;
        reads = 0; writes = 0; t_last = -1; t_done_exp = -1; dones = 0; start_occ = exp_occ;
        drive(1'b1, 1'b1, 16'(n), 1'b0, 1'b0);
        n_chk++;
        if (dbuf_rd_en !== 1'b0 || layer_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL op_cycle: rd_en=%0b busy=%0b, required 0 0", dbuf_rd_en, layer_busy);
        end
        for (int cyc = 0; cyc < 600 && dones == 0; cyc++) begin
            rdy = (mode == 2) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : ($urandom_range(0, 2) != 0);
            wr  = (writes < wr_more) && ($urandom_range(0, 1) == 1);
            if (wr) writes++;
            op2 = extra_op && (cyc == 2);
            drive(1'b1, op2, op2 ? 16'(n + 5) : 16'(n), wr, rdy);
            if (op2) exp_err = ERR_EN;
            if (dbuf_rd_en) begin
                n_chk++;
                if (!rdy || reads >= n) begin
                    n_fail++;
                    $display("FAIL rd_legal: read %0d with ready=%0b, required ready=1 and at most %0d reads",
                             reads, rdy, n);
                end
                n_chk++;
                if (dbuf_rd_addr !== 4'((exp_ptr + reads) % 16)) begin
                    n_fail++;
                    $display("FAIL rd_addr: read %0d addr=%0d, required %0d",
                             reads, dbuf_rd_addr, (exp_ptr + reads) % 16);
                end
                n_chk++;
                if (dbuf_rd_layer_end !== (reads == n - 1)) begin
                    n_fail++;
                    $display("FAIL layer_end: read %0d layer_end=%0b, required %0b",
                             reads, dbuf_rd_layer_end, reads == n - 1);
                end
                if (reads == n - 1) t_last = cyc;
                reads++;
            end
            if (t_last >= 0 && cyc > t_last && rdy && t_done_exp < 0) t_done_exp = cyc + 1;
            if (layer_done) begin
                dones++;
                n_chk++;
                if (cyc != t_done_exp) begin
                    n_fail++;
                    $display("FAIL done_time: layer_done at cycle %0d, required %0d", cyc, t_done_exp);
                end
            end
        end
        n_chk++;
        if (dones != 1 || reads != n) begin
            n_fail++;
            $display("FAIL layer_complete: dones=%0d reads=%0d, required 1 and %0d", dones, reads, n);
        end
        drive(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
        n_chk++;
        if (layer_done !== 1'b0 || layer_busy !== 1'b0 || dbuf_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done: done=%0b busy=%0b rd_en=%0b, required 0 0 0",
                     layer_done, layer_busy, dbuf_rd_en);
        end
        while (writes < wr_more) begin
            drive(1'b1, 1'b0, 16'd0, 1'b1, 1'b0);
            writes++;
        end
        drive(1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
        exp_ptr = (exp_ptr + n) % 16;
        exp_occ = start_occ + writes - n;
        check_status("layer_status");
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'd0, 1'b1, 1'b1);
        n_chk++;
        if ({dbuf_rd_en, dbuf_rd_addr, dbuf_rd_layer_end, dbuf_full, dbuf_occ,
             layer_busy, layer_done, sched_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: rd_en=%0b addr=%0d end=%0b full=%0b occ=%0d busy=%0b done=%0b err=%0b, required all 0",
                     dbuf_rd_en, dbuf_rd_addr, dbuf_rd_layer_end, dbuf_full, dbuf_occ,
                     layer_busy, layer_done, sched_err);
        end
        drive(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
        exp_ptr = 0; exp_occ = 0; exp_err = 1'b0;
        check_status("reset_release");
    endtask

    task automatic test_basic();
        prefill(3);
        run_layer(3, 0, 1, 1'b0);
    endtask

    task automatic test_wrap();
        prefill(11);
        run_layer(11, 0, 0, 1'b0);
        n_chk++;
        if (dbuf_rd_addr !== 4'd14) begin
            n_fail++;
            $display("FAIL wrap_start: addr=%0d, required 14", dbuf_rd_addr);
        end
        prefill(4);
        run_layer(4, 0, 0, 1'b0);
    endtask

    task automatic test_full();
        prefill(16);
        drive(1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
        check_status("full_16");
        drive(1'b1, 1'b0, 16'd0, 1'b1, 1'b0);
        exp_err = ERR_EN;
        drive(1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
        check_status("overflow_saturate");
        run_layer(16, 0, 0, 1'b0);
    endtask

    task automatic test_simultaneous();
        bit seen;
        prefill(5);
        drive(1'b1, 1'b1, 16'd1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'd0, 1'b1, 1'b1);
        n_chk++;
        if (dbuf_rd_en !== 1'b1 || dbuf_rd_layer_end !== 1'b1 || dbuf_rd_addr !== 4'(exp_ptr)) begin
            n_fail++;
            $display("FAIL simul_read: rd_en=%0b end=%0b addr=%0d, required 1 1 %0d",
                     dbuf_rd_en, dbuf_rd_layer_end, dbuf_rd_addr, exp_ptr);
        end
        drive(1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
        check_status("simul_occ");
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            drive(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
            seen = layer_done;
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL simul_done: layer_done=0 within 10 cycles, required 1");
        end
        drive(1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
        exp_ptr = (exp_ptr + 1) % 16;
    endtask

    task automatic test_zero_entries();
        drive(1'b1, 1'b1, 16'd0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
        n_chk++;
        if (layer_done !== 1'b1 || layer_busy !== 1'b1 || dbuf_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: done=%0b busy=%0b rd_en=%0b, required 1 1 0",
                     layer_done, layer_busy, dbuf_rd_en);
        end
        drive(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
        n_chk++;
        if (layer_done !== 1'b0 || layer_busy !== 1'b0 || dbuf_rd_en !== 1'b0 ||
            dbuf_rd_addr !== 4'(exp_ptr)) begin
            n_fail++;
            $display("FAIL zero_after: done=%0b busy=%0b rd_en=%0b addr=%0d, required 0 0 0 %0d",
                     layer_done, layer_busy, dbuf_rd_en, dbuf_rd_addr, exp_ptr);
        end
        check_status("zero_status");
    endtask

    task automatic test_reset_in_drain();
        drive(1'b1, 1'b1, 16'd2, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
        n_chk++;
        if (layer_busy !== 1'b1 || layer_done !== 1'b0 || dbuf_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_state: busy=%0b done=%0b rd_en=%0b, required 1 0 0",
                     layer_busy, layer_done, dbuf_rd_en);
        end
        drive(1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
        n_chk++;
        if ({dbuf_rd_en, dbuf_rd_addr, dbuf_rd_layer_end, dbuf_full, dbuf_occ,
             layer_busy, layer_done, sched_err} !== '0) begin
            n_fail++;
            $display("FAIL drain_reset: rd_en=%0b addr=%0d end=%0b full=%0b occ=%0d busy=%0b done=%0b err=%0b, required all 0",
                     dbuf_rd_en, dbuf_rd_addr, dbuf_rd_layer_end, dbuf_full, dbuf_occ,
                     layer_busy, layer_done, sched_err);
        end
        exp_ptr = 0; exp_occ = 0; exp_err = 1'b0;
        prefill(2);
        run_layer(2, 0, 2, 1'b0);
    endtask

    task automatic test_random();
        int n, p;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 16 - exp_occ);
            p = $urandom_range(0, n);
            prefill(p);
            run_layer(n, n - p, 0, (it % 2) == 1);
        end
    endtask

    initial begin
        rstn = 1'b0; reg_op_en = 1'b0; reg_layer_entries = '0; wr_done = 1'b0; dbuf_rd_ready = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_full();
        test_simultaneous();
        test_zero_entries();
        test_reset_in_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at 500000, required completion");
        $fatal(1, "timeout");
    end

endmodule
